// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to packed BCD converter, one bit per clock.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic [BIN_WIDTH-1:0]  bin_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  valid_o,
  output logic                  overflow_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = ((BIN_WIDTH > BW) ? BIN_WIDTH : BW) + 1;
  localparam int NW = $clog2(BIN_WIDTH + 1);

  // 10^DIGITS always fits in 4*DIGITS bits, so CW is wide enough.
  function automatic logic [CW-1:0] pow10();
    logic [CW-1:0] p;
    p = {{(CW-1){1'b0}}, 1'b1};
    for (int i = 0; i < DIGITS; i++) begin
      p = p * {{(CW-4){1'b0}}, 4'd10};
    end
    return p;
  endfunction

  localparam logic [CW-1:0] LIMIT = pow10();

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t                 r_state;
  logic [BIN_WIDTH-1:0]   r_shift;
  logic [BW-1:0]          r_scratch;
  logic [NW-1:0]          r_cnt;
  logic                   r_ovf;

  logic [CW-1:0]          w_bin_ext;
  logic                   w_over;
  logic [BW-1:0]          w_adj;
  logic [BW-1:0]          w_final;

  assign w_bin_ext = {{(CW-BIN_WIDTH){1'b0}}, bin_i};
  assign w_over    = (w_bin_ext >= LIMIT);

  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_seen;

  // Blank from the top down until the first nonzero digit; digit 0 stays.
  always_comb begin
    w_final = r_scratch;
    w_seen  = 1'b0;
    if (!r_ovf) begin
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (!w_seen && (r_scratch[4*d +: 4] == 4'd0)) begin
          w_final[4*d +: 4] = 4'hF;
        end else begin
          w_seen = 1'b1;
        end
      end
    end
  end
`else
  assign w_final = r_scratch;
`endif

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      bcd_o      <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      ready_o    <= 1'b1;
    end else begin
      valid_o <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_shift <= bin_i;
            ready_o <= 1'b0;
            if (w_over) begin
              r_scratch <= {DIGITS{4'h9}};
              r_ovf     <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_scratch <= '0;
              r_ovf     <= 1'b0;
              r_cnt     <= NW'(BIN_WIDTH);
              r_state   <= CONVERT;
            end
          end
        end
        CONVERT: begin
          r_scratch <= {w_adj[BW-2:0], r_shift[BIN_WIDTH-1]};
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt - 1'b1;
          if (r_cnt == NW'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          bcd_o      <= w_final;
          overflow_o <= r_ovf;
          valid_o    <= 1'b1;
          ready_o    <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq.
// Expected values follow LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_i;
  logic [13:0] bin_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] bcd_o;
  logic        valid_o;
  logic        overflow_o;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [15:0] E0  = 16'hFFF0;
  localparam logic [15:0] E5  = 16'hFFF5;
  localparam logic [15:0] E42 = 16'hFF42;
`else
  localparam logic [15:0] E0  = 16'h0000;
  localparam logic [15:0] E5  = 16'h0005;
  localparam logic [15:0] E42 = 16'h0042;
`endif

  bin_to_bcd_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .bin_i      (bin_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .bcd_o      (bcd_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (valid_o) pulses++;

  task automatic accept(input logic [13:0] v);
    bin_i   = v;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!valid_o && n < 40);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    valid_i = 1'b0;
    bin_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", ready_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", valid_o);
    end
    checks++;
    if (bcd_o !== 16'h0000) begin
      errors++; $display("FAIL reset_bcd got %h want 0000", bcd_o);
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", overflow_o);
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int n;
    accept(14'd1234);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL basic_busy got %b want 0", ready_o);
    end
    wait_valid(n);
    checks++;
    if (n !== 15) begin
      errors++; $display("FAIL basic_latency got %0d want 15", n);
    end
    checks++;
    if (bcd_o !== 16'h1234) begin
      errors++; $display("FAIL basic_bcd got %h want 1234", bcd_o);
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++; $display("FAIL basic_ovf got %b want 0", overflow_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL basic_ready got %b want 1", ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_pulse got %b want 0", valid_o);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int p0;
    p0 = pulses;
    accept(14'd0);
    wait_valid(n);
    checks++;
    if (n !== 15) begin
      errors++; $display("FAIL b2b_lat0 got %0d want 15", n);
    end
    checks++;
    if (bcd_o !== E0) begin
      errors++; $display("FAIL b2b_bcd0 got %h want %h", bcd_o, E0);
    end
    accept(14'd9999);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got v=%b r=%b want v=0 r=0", valid_o, ready_o);
    end
    checks++;
    if (bcd_o !== E0) begin
      errors++; $display("FAIL b2b_hold got %h want %h", bcd_o, E0);
    end
    wait_valid(n);
    checks++;
    if (n !== 15) begin
      errors++; $display("FAIL b2b_lat1 got %0d want 15", n);
    end
    checks++;
    if (bcd_o !== 16'h9999) begin
      errors++; $display("FAIL b2b_bcd1 got %h want 9999", bcd_o);
    end
    @(negedge clk); #1;
    checks++;
    if (pulses - p0 !== 2) begin
      errors++; $display("FAIL b2b_pulses got %0d want 2", pulses - p0);
    end
  endtask

  task automatic test_overflow;
    int n;
    accept(14'd10000);
    wait_valid(n);
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL ovf_latency got %0d want 1", n);
    end
    checks++;
    if (bcd_o !== 16'h9999) begin
      errors++; $display("FAIL ovf_bcd got %h want 9999", bcd_o);
    end
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %b want 1", overflow_o);
    end
    @(posedge clk); #1;
    accept(14'd5);
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++; $display("FAIL ovf_hold got %b want 1", overflow_o);
    end
    wait_valid(n);
    checks++;
    if (bcd_o !== E5) begin
      errors++; $display("FAIL ovf_next_bcd got %h want %h", bcd_o, E5);
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b want 0", overflow_o);
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    int p0;
    @(posedge clk); #1;
    p0 = pulses;
    bin_i   = 14'd4321;
    valid_i = 1'b1;
    @(posedge clk); #1;
    bin_i = 14'd7777;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL busy_ready got %b want 0", ready_o);
    end
    wait_valid(n);
    checks++;
    if (n !== 15 || bcd_o !== 16'h4321) begin
      errors++;
      $display("FAIL busy_first got lat=%0d bcd=%h want lat=15 bcd=4321", n, bcd_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_valid(n);
    checks++;
    if (n !== 15 || bcd_o !== 16'h7777) begin
      errors++;
      $display("FAIL busy_second got lat=%0d bcd=%h want lat=15 bcd=7777", n, bcd_o);
    end
    @(negedge clk); #1;
    checks++;
    if (pulses - p0 !== 2) begin
      errors++; $display("FAIL busy_pulses got %0d want 2", pulses - p0);
    end
  endtask

  task automatic test_abort;
    int n;
    int p0;
    @(posedge clk); #1;
    accept(14'd8888);
    p0 = pulses;
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got r=%b v=%b want r=1 v=0", ready_o, valid_o);
    end
    checks++;
    if (bcd_o !== 16'h0000) begin
      errors++; $display("FAIL abort_bcd got %h want 0000", bcd_o);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (pulses !== p0) begin
      errors++; $display("FAIL abort_pulse got %0d want 0", pulses - p0);
    end
    accept(14'd42);
    wait_valid(n);
    checks++;
    if (n !== 15 || bcd_o !== E42) begin
      errors++;
      $display("FAIL abort_next got lat=%0d bcd=%h want lat=15 bcd=%h", n, bcd_o, E42);
    end
  endtask

  task automatic test_blank;
    int n;
    @(posedge clk); #1;
    accept(14'd1005);
    wait_valid(n);
    checks++;
    if (bcd_o !== 16'h1005) begin
      errors++; $display("FAIL blank_1005 got %h want 1005", bcd_o);
    end
    @(posedge clk); #1;
    accept(14'd12000);
    wait_valid(n);
    checks++;
    if (bcd_o !== 16'h9999 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL blank_sat got %h/%b want 9999/1", bcd_o, overflow_o);
    end
    @(posedge clk); #1;
    accept(14'd0);
    wait_valid(n);
    checks++;
    if (bcd_o !== E0) begin
      errors++; $display("FAIL blank_zero got %h want %h", bcd_o, E0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_overflow;
    test_busy_ignore;
    test_abort;
    test_blank;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
